aq_fcnvt_ftoi_ctrl: RTL and testbench
=====================================

# aq_fcnvt_ftoi_ctrl

Two-requester sequencer for the double-precision float-to-integer convert datapath in the vfalu. It arbitrates between the scalar FPU pipe (requester 0) and the vector lane pipe (requester 1). Each accepted operand is unpacked into a shift count and a 53-bit significand and driven through the shared `aq_fcnvt_ftoi_d` shifter. The controller then rounds, negates and saturates the result and returns it with RISC-V fflags through a two-stage valid/ready pipeline.

## Interface
- `TAG_W`, default 5: width of the requester tag carried through unchanged.
- `cpuclk` in 1: clock.
- `cpurst_b` in 1: reset, asynchronous, active-low.
- `ctrl_flush` in 1: synchronous kill of all in-flight entries.
- `req_vld` in 2: request valid, bit i = requester i.
- `req_rdy` out 2: request accepted this cycle when `req_vld[i] & req_rdy[i]`.
- `req_src` in 128: IEEE double operands, `[64i+63:64i]`.
- `req_rm` in 6: rounding mode, `[3i+2:3i]`. Encodings: RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4; 5-7 behave as RTZ.
- `req_unsigned` in 2: 1 selects wu/lu, 0 selects w/l.
- `req_word` in 2: 1 selects a 32-bit destination, 0 a 64-bit destination.
- `req_tag` in 2*TAG_W: opaque tag.
- `res_vld` out 1; `res_rdy` in 1: result handshake.
- `res_id` out 1: originating requester.
- `res_tag` out TAG_W: tag of the result.
- `res_data` out 64: integer result; word results are sign-extended from bit 31.
- `res_fflags` out 5: {NV,DZ,OF,UF,NX}; DZ, OF and UF are always 0.

## Operation
- Arbitration is round-robin. The `rr_ptr` register names the preferred requester.
  - `req_rdy[i]` = S1 free-or-advancing & (only i valid | i is preferred).
  - On accept, `rr_ptr` moves to the other requester.
  - When only one requester is valid it wins every cycle.
- S1 register holds {src, rm, unsigned, word, id, tag} plus a valid bit.
- S1 combinational path:
  - Unbiased exponent e = exp - 1023, 12-bit signed. Shifter source = {exp!=0, frac}.
  - For -1 <= e <= 63: drive shift count e[6:0] (e=-1 gives 7'h7f). Integer part = shifter integer output. Round bit = fraction output bit 53. Sticky = OR of fraction output [52:0].
  - For e < -1, including subnormals and zero: bypass the shifter, whose output is undefined there. Integer part = 0, round bit = 0, sticky = |significand.
  - For exp = 0x7FF: NaN, or ±inf when frac = 0.
- Rounding uses the sign, the LSB of the integer part, the round bit (r) and sticky (s) to decide increment inc:
  - RNE: r & (s | lsb)
  - RTZ: 0
  - RDN: sign & (r|s)
  - RUP: !sign & (r|s)
  - RMM: r
  - Magnitude is 65 bits so a carry out at e=63 is kept.
- Range limits:
  - Signed: max 2^31-1 / 2^63-1; min -2^31 / -2^63. Magnitude 2^31 / 2^63 is legal only when negative.
  - Unsigned: max 2^32-1 / 2^64-1. A negative operand whose rounded magnitude is nonzero is invalid.
- Exception results:
  - NaN: NV, result = positive max.
  - +inf or positive out of range: NV, positive max.
  - -inf or negative out of range: NV, signed min, or 0 for unsigned.
- In-range results: sign applied (two's complement), NX = r|s, NV = 0. NX is never set together with NV.
- S2 register holds {data, fflags, id, tag} and a valid bit.
  - S1 advances into S2 when S2 is empty or `res_rdy` is 1.
  - S2 data and flags hold steady while `res_vld & !res_rdy`.

## Timing
- Reset values: `res_vld`=0, `res_data`=0, `res_fflags`=0, `res_id`=0, `res_tag`=0, `rr_ptr`=0, S1 valid=0, `req_rdy` driven only by combinational logic of reset state.
- Latency: accept at edge N produces `res_vld`=1 after edge N+1, visible in cycle N+1.
- Throughput is 1 per cycle with `res_rdy` held high.
- Full pipeline (S1 and S2 valid, `res_rdy`=0): `req_rdy`=0 for both requesters; no entry is lost or duplicated.
- Simultaneous accept and drain in the same cycle is legal: S2 takes S1 and S1 takes the new request.
- `ctrl_flush`=1: both valid bits clear at the next edge, `req_rdy`=0 that cycle, and no result is produced for killed entries.
- Flush has priority over accept. `rr_ptr` does not change on flush.
- Asynchronous reset mid-operation drops all entries immediately.

## Structure
- Shared constants header for the vfalu:
  - rounding-mode encodings;
  - fflags bit indices;
  - double bias 1023;
  - the four saturation constants.
- Sub-modules:
  - `aq_fcnvt_ftoi_d` is the shared shifter, instantiated once in S1.
  - `aq_fcnvt_ftoi_rnd` is new and purely combinational: rounding, range check, negation and fflags, placed between S1 and S2.
- Arbiter, S1/S2 registers and flush live in the top-level controller.

## Test plan
- Req0 1.5 (0x3FF8000000000000), RNE, signed long, `res_rdy`=1: `res_data`=2 with `res_fflags`=0x01 two cycles later; 2.0 gives 2 with flags 0.
- Req1 -2.5 (0xC004000000000000), RNE, signed long: `res_data`=0xFFFFFFFFFFFFFFFE, NX. Same operand with RMM: 0xFFFFFFFFFFFFFFFD, NX.
- Range and invalid cases:
  - 0x7FF8000000000000 (NaN), signed word: 0x000000007FFFFFFF, NV (0x10).
  - 2^63 (0x43E0000000000000), signed long: 0x7FFFFFFFFFFFFFFF, NV.
  - 2^63 (0x43E0000000000000), unsigned long: 0x8000000000000000, flags 0.
  - -0.25, unsigned, RTZ: 0, NX. -1.0, unsigned: 0, NV.
- Both requesters valid for 4 cycles: grants alternate 0,1,0,1 and results return in order with correct `res_id` and `res_tag`.
- Hold `res_rdy`=0 for 5 cycles with both valid: exactly 2 entries held, `req_rdy`=0, and after release the results drain with no loss.
- Assert `ctrl_flush` with S1 and S2 full: `res_vld`=0 next cycle and no stale results. Async reset mid-stream: all outputs return to reset values immediately.

Source files
------------

// File: rtl/aq_fcnvt_ftoi_ctrl_pkg.sv
// aq_fcnvt_ftoi_ctrl_pkg: shared vfalu constants for double-to-integer conversion
//   rounding-mode encodings, fflags bit indices, double bias, saturation magnitudes
package aq_fcnvt_ftoi_ctrl_pkg;
  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;
  localparam logic [11:0] DBL_BIAS = 12'd1023;
  localparam logic [64:0] SMAX_W = 65'h0_0000_0000_7FFF_FFFF;
  localparam logic [64:0] SMAX_L = 65'h0_7FFF_FFFF_FFFF_FFFF;
  localparam logic [64:0] UMAX_W = 65'h0_0000_0000_FFFF_FFFF;
  localparam logic [64:0] UMAX_L = 65'h0_FFFF_FFFF_FFFF_FFFF;
  function automatic logic [63:0] sext_w(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction
endpackage

// File: rtl/aq_fcnvt_ftoi_d.sv
// aq_fcnvt_ftoi_d: shared significand shifter splitting a double into integer and fraction
//   shift: unbiased exponent e[6:0] (valid for -1..63), sig: {hidden, frac}
//   ipart: integer part, frac: fraction bits, frac[53] is the half-ulp (round) bit
module aq_fcnvt_ftoi_d (
  input  logic [6:0]  shift,
  input  logic [52:0] sig,
  output logic [63:0] ipart,
  output logic [53:0] frac
);
  logic [6:0]   s;
  logic [117:0] v;
  // e+1 wraps e=-1 to zero; the extra low zero places the binary point at bit 54
  assign s     = shift + 7'd1;
  assign v     = {64'b0, sig, 1'b0} << s;
  assign ipart = v[117:54];
  assign frac  = v[53:0];
endmodule

// File: rtl/aq_fcnvt_ftoi_rnd.sv
// aq_fcnvt_ftoi_rnd: rounding, range check, negation and fflags for float-to-integer
//   sign/rm/uns/word: operand sign and conversion type, nan/big: NaN and out-of-shifter-range
//   ipart/r/s: truncated magnitude, round and sticky bits
//   data: integer result (word sign-extended), fflags: {NV,DZ,OF,UF,NX}
module aq_fcnvt_ftoi_rnd
  import aq_fcnvt_ftoi_ctrl_pkg::*;
(
  input  logic        sign,
  input  logic [2:0]  rm,
  input  logic        uns,
  input  logic        word,
  input  logic        nan,
  input  logic        big,
  input  logic [63:0] ipart,
  input  logic        r,
  input  logic        s,
  output logic [63:0] data,
  output logic [4:0]  fflags
);
  logic        inc, nv;
  logic [64:0] mag, lim;
  logic [63:0] val;
  always_comb begin
    inc = rm == RM_RNE ? r & (s | ipart[0]) :
          rm == RM_RDN ? sign & (r | s) :
          rm == RM_RUP ? !sign & (r | s) :
          rm == RM_RMM ? r : 1'b0;
    mag = {1'b0, ipart} + 65'(inc);
    lim = uns ? (word ? UMAX_W : UMAX_L) : (word ? SMAX_W : SMAX_L);
    // negative signed results may reach one past the positive limit
    nv  = nan | big | (sign ? (uns ? mag != '0 : mag > lim + 65'd1) : mag > lim);
    val = !nv ? (sign ? -mag[63:0] : mag[63:0]) :
          (nan | !sign) ? lim[63:0] :
          uns ? 64'd0 : ~lim[63:0];
    data = word ? sext_w(val) : val;
    fflags = '0;
    fflags[FF_NV] = nv;
    fflags[FF_NX] = !nv & (r | s);
  end
endmodule

// File: rtl/aq_fcnvt_ftoi_ctrl.sv
// aq_fcnvt_ftoi_ctrl: two-requester round-robin sequencer for double-to-integer conversion
//   cpuclk/cpurst_b: clock and async active-low reset, ctrl_flush: kill all in-flight entries
//   req_*: per-requester operand, rounding mode, type and tag with valid/ready
//   res_*: integer result, fflags, requester id and tag with valid/ready
module aq_fcnvt_ftoi_ctrl
  import aq_fcnvt_ftoi_ctrl_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic               cpuclk,
  input  logic               cpurst_b,
  input  logic               ctrl_flush,
  input  logic [1:0]         req_vld,
  output logic [1:0]         req_rdy,
  input  logic [127:0]       req_src,
  input  logic [5:0]         req_rm,
  input  logic [1:0]         req_unsigned,
  input  logic [1:0]         req_word,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic               res_vld,
  input  logic               res_rdy,
  output logic               res_id,
  output logic [TAG_W-1:0]   res_tag,
  output logic [63:0]        res_data,
  output logic [4:0]         res_fflags
);
  logic             s1_vld, s2_vld, rr_ptr, s1_adv, s1_free, gnt, acc;
  logic [63:0]      s1_src;
  logic [2:0]       s1_rm;
  logic             s1_uns, s1_word, s1_id;
  logic [TAG_W-1:0] s1_tag;
  logic [10:0]      expo;
  logic [11:0]      e;
  logic [52:0]      sig;
  logic             in_rng, big, nan;
  logic [63:0]      sh_int, rnd_data;
  logic [53:0]      sh_frac;
  logic [4:0]       rnd_ff;
  assign s1_adv  = !s2_vld | res_rdy;
  assign s1_free = !s1_vld | s1_adv;
  always_comb begin
    req_rdy[0] = s1_free & !ctrl_flush & ((req_vld[0] & !req_vld[1]) | !rr_ptr);
    req_rdy[1] = s1_free & !ctrl_flush & ((req_vld[1] & !req_vld[0]) | rr_ptr);
  end
  assign gnt = req_vld[1] & req_rdy[1];
  assign acc = |(req_vld & req_rdy);
  always_ff @(posedge cpuclk or negedge cpurst_b)
    if (!cpurst_b) begin
      s1_vld  <= 1'b0;
      rr_ptr  <= 1'b0;
      s1_src  <= '0;
      s1_rm   <= '0;
      s1_uns  <= 1'b0;
      s1_word <= 1'b0;
      s1_id   <= 1'b0;
      s1_tag  <= '0;
    end else if (!ctrl_flush) begin
      if (s1_free) s1_vld <= acc;
      if (acc) begin
        rr_ptr  <= !gnt;
        s1_src  <= gnt ? req_src[127:64] : req_src[63:0];
        s1_rm   <= gnt ? req_rm[5:3] : req_rm[2:0];
        s1_uns  <= req_unsigned[gnt];
        s1_word <= req_word[gnt];
        s1_id   <= gnt;
        s1_tag  <= gnt ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
      end
    end else s1_vld <= 1'b0;
  assign expo   = s1_src[62:52];
  assign e      = {1'b0, expo} - DBL_BIAS;
  assign sig    = {expo != '0, s1_src[51:0]};
  assign nan    = &expo & |s1_src[51:0];
  assign big    = $signed(e) > 12'sd63;
  assign in_rng = !big & ($signed(e) >= -12'sd1);
  aq_fcnvt_ftoi_d u_shf (
    .shift (e[6:0]),
    .sig   (sig),
    .ipart (sh_int),
    .frac  (sh_frac)
  );
  // below e=-1 the shifter output is meaningless; only stickiness survives
  aq_fcnvt_ftoi_rnd u_rnd (
    .sign   (s1_src[63]),
    .rm     (s1_rm),
    .uns    (s1_uns),
    .word   (s1_word),
    .nan    (nan),
    .big    (big),
    .ipart  (in_rng ? sh_int : 64'd0),
    .r      (in_rng & sh_frac[53]),
    .s      (in_rng ? |sh_frac[52:0] : |sig),
    .data   (rnd_data),
    .fflags (rnd_ff)
  );
  always_ff @(posedge cpuclk or negedge cpurst_b)
    if (!cpurst_b) begin
      s2_vld     <= 1'b0;
      res_data   <= '0;
      res_fflags <= '0;
      res_id     <= 1'b0;
      res_tag    <= '0;
    end else if (ctrl_flush) s2_vld <= 1'b0;
    else if (s1_adv) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        res_data   <= rnd_data;
        res_fflags <= rnd_ff;
        res_id     <= s1_id;
        res_tag    <= s1_tag;
      end
    end
  assign res_vld = s2_vld;
endmodule

// File: tb/tb_aq_fcnvt_ftoi_ctrl.sv
// tb_aq_fcnvt_ftoi_ctrl: directed self-checking bench for the float-to-integer sequencer
module tb_aq_fcnvt_ftoi_ctrl;
  localparam int TAG_W = 5;
  logic               cpuclk = 1'b0, cpurst_b = 1'b1, ctrl_flush = 1'b0, res_rdy = 1'b1;
  logic [1:0]         req_vld = '0, req_unsigned = '0, req_word = '0;
  logic [1:0]         req_rdy;
  logic [127:0]       req_src = '0;
  logic [5:0]         req_rm = '0;
  logic [2*TAG_W-1:0] req_tag = '0;
  logic               res_vld, res_id;
  logic [TAG_W-1:0]   res_tag;
  logic [63:0]        res_data;
  logic [4:0]         res_fflags;
  int                 tests = 0, fails = 0, acc_cnt = 0;
  always #5 cpuclk = ~cpuclk;
  aq_fcnvt_ftoi_ctrl #(.TAG_W(TAG_W)) dut (
    .cpuclk       (cpuclk),
    .cpurst_b     (cpurst_b),
    .ctrl_flush   (ctrl_flush),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_src      (req_src),
    .req_rm       (req_rm),
    .req_unsigned (req_unsigned),
    .req_word     (req_word),
    .req_tag      (req_tag),
    .res_vld      (res_vld),
    .res_rdy      (res_rdy),
    .res_id       (res_id),
    .res_tag      (res_tag),
    .res_data     (res_data),
    .res_fflags   (res_fflags)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic set_req(input int q, input logic [63:0] src, input logic [2:0] rm,
                         input logic uns, input logic word, input logic [TAG_W-1:0] tag);
    req_vld[q] = 1'b1;
    req_src[64*q +: 64] = src;
    req_rm[3*q +: 3] = rm;
    req_unsigned[q] = uns;
    req_word[q] = word;
    req_tag[TAG_W*q +: TAG_W] = tag;
  endtask
  task automatic do_reset();
    @(negedge cpuclk);
    req_vld = '0;
    ctrl_flush = 1'b0;
    res_rdy = 1'b1;
    cpurst_b = 1'b0;
    @(negedge cpuclk);
    cpurst_b = 1'b1;
  endtask
  task automatic run1(input string name, input int q, input logic [63:0] src, input logic [2:0] rm,
                      input logic uns, input logic word, input logic [63:0] ed, input logic [4:0] ef);
    logic [TAG_W-1:0] t;
    t = TAG_W'(q + 20);
    @(negedge cpuclk);
    set_req(q, src, rm, uns, word, t);
    #1 check({name, " rdy"}, 64'(req_rdy[q]), 64'd1);
    @(negedge cpuclk);
    req_vld = '0;
    check({name, " lat"}, 64'(res_vld), 64'd0);
    @(negedge cpuclk);
    check({name, " vld"}, 64'(res_vld), 64'd1);
    check({name, " data"}, res_data, ed);
    check({name, " ff"}, 64'(res_fflags), 64'(ef));
    check({name, " id"}, 64'(res_id), 64'(q));
    check({name, " tag"}, 64'(res_tag), 64'(t));
  endtask
  initial begin
    #2 cpurst_b = 1'b0;
    #1;
    check("rst vld", 64'(res_vld), 64'd0);
    check("rst data", res_data, 64'd0);
    check("rst ff", 64'(res_fflags), 64'd0);
    check("rst id", 64'(res_id), 64'd0);
    check("rst tag", 64'(res_tag), 64'd0);
    check("rst rdy", 64'(req_rdy), 64'd1);
    @(negedge cpuclk);
    cpurst_b = 1'b1;
    run1("p1.5 rne",   0, 64'h3FF8000000000000, 3'd0, 1'b0, 1'b0, 64'd2, 5'h01);
    run1("p2.0 rne",   0, 64'h4000000000000000, 3'd0, 1'b0, 1'b0, 64'd2, 5'h00);
    run1("m2.5 rne",   1, 64'hC004000000000000, 3'd0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFE, 5'h01);
    run1("m2.5 rmm",   1, 64'hC004000000000000, 3'd4, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFD, 5'h01);
    run1("nan w",      0, 64'h7FF8000000000000, 3'd0, 1'b0, 1'b1, 64'h000000007FFFFFFF, 5'h10);
    run1("2^63 l",     1, 64'h43E0000000000000, 3'd0, 1'b0, 1'b0, 64'h7FFFFFFFFFFFFFFF, 5'h10);
    run1("2^63 lu",    0, 64'h43E0000000000000, 3'd0, 1'b1, 1'b0, 64'h8000000000000000, 5'h00);
    run1("m0.25 u",    1, 64'hBFD0000000000000, 3'd1, 1'b1, 1'b0, 64'd0, 5'h01);
    run1("m1.0 u",     0, 64'hBFF0000000000000, 3'd1, 1'b1, 1'b0, 64'd0, 5'h10);
    run1("minf w",     1, 64'hFFF0000000000000, 3'd0, 1'b0, 1'b1, 64'hFFFFFFFF80000000, 5'h10);
    run1("p0.5 rne",   0, 64'h3FE0000000000000, 3'd0, 1'b0, 1'b0, 64'd0, 5'h01);
    run1("subn rup",   1, 64'h0000000000000001, 3'd3, 1'b0, 1'b0, 64'd1, 5'h01);
    run1("m0.5 rdn",   0, 64'hBFE0000000000000, 3'd2, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 5'h01);
    run1("2^31 w",     1, 64'h41E0000000000000, 3'd0, 1'b0, 1'b1, 64'h000000007FFFFFFF, 5'h10);
    run1("m2^31 w",    0, 64'hC1E0000000000000, 3'd0, 1'b0, 1'b1, 64'hFFFFFFFF80000000, 5'h00);
    run1("2^32-1 wu",  1, 64'h41EFFFFFFFE00000, 3'd0, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 5'h00);
    run1("p1.5 rm7 w", 0, 64'h3FF8000000000000, 3'd7, 1'b0, 1'b1, 64'd1, 5'h01);
    do_reset();
    set_req(0, 64'h3FF0000000000000, 3'd0, 1'b0, 1'b0, 5'd3);
    set_req(1, 64'h4000000000000000, 3'd0, 1'b0, 1'b0, 5'd9);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) req_vld = '0;
      #1;
      if (i < 4) check("arb rdy", 64'(req_rdy), (i % 2) ? 64'd2 : 64'd1);
      if (i >= 2) begin
        check("arb vld", 64'(res_vld), 64'd1);
        check("arb id", 64'(res_id), 64'((i - 2) % 2));
        check("arb tag", 64'(res_tag), (i % 2) ? 64'd9 : 64'd3);
        check("arb data", res_data, (i % 2) ? 64'd2 : 64'd1);
      end
      @(negedge cpuclk);
    end
    #1 check("arb idle", 64'(res_vld), 64'd0);
    do_reset();
    res_rdy = 1'b0;
    set_req(0, 64'h3FF0000000000000, 3'd0, 1'b0, 1'b0, 5'd1);
    set_req(1, 64'h4000000000000000, 3'd0, 1'b0, 1'b0, 5'd2);
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1 acc_cnt += $countones(req_vld & req_rdy);
      if (i >= 2) begin
        check("stall rdy", 64'(req_rdy), 64'd0);
        check("stall vld", 64'(res_vld), 64'd1);
        check("stall id", 64'(res_id), 64'd0);
        check("stall data", res_data, 64'd1);
      end
      @(negedge cpuclk);
    end
    check("stall accepts", 64'(acc_cnt), 64'd2);
    req_vld = '0;
    res_rdy = 1'b1;
    #1;
    check("drain0 vld", 64'(res_vld), 64'd1);
    check("drain0 tag", 64'(res_tag), 64'd1);
    @(negedge cpuclk);
    #1;
    check("drain1 vld", 64'(res_vld), 64'd1);
    check("drain1 id", 64'(res_id), 64'd1);
    check("drain1 tag", 64'(res_tag), 64'd2);
    check("drain1 data", res_data, 64'd2);
    @(negedge cpuclk);
    #1 check("drain end", 64'(res_vld), 64'd0);
    do_reset();
    res_rdy = 1'b0;
    set_req(0, 64'h3FF0000000000000, 3'd0, 1'b0, 1'b0, 5'd4);
    set_req(1, 64'h4000000000000000, 3'd0, 1'b0, 1'b0, 5'd5);
    @(negedge cpuclk);
    @(negedge cpuclk);
    ctrl_flush = 1'b1;
    #1;
    check("flush full vld", 64'(res_vld), 64'd1);
    check("flush full rdy", 64'(req_rdy), 64'd0);
    @(negedge cpuclk);
    ctrl_flush = 1'b0;
    req_vld = '0;
    res_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("flush kill", 64'(res_vld), 64'd0);
      @(negedge cpuclk);
    end
    set_req(0, 64'h4000000000000000, 3'd0, 1'b0, 1'b0, 5'd6);
    ctrl_flush = 1'b1;
    #1 check("flush rdy", 64'(req_rdy), 64'd0);
    @(negedge cpuclk);
    ctrl_flush = 1'b0;
    req_vld = '0;
    for (int i = 0; i < 2; i++) begin
      #1 check("flush noacc", 64'(res_vld), 64'd0);
      @(negedge cpuclk);
    end
    do_reset();
    res_rdy = 1'b0;
    set_req(1, 64'h4000000000000000, 3'd0, 1'b0, 1'b0, 5'd7);
    @(negedge cpuclk);
    req_vld = '0;
    @(negedge cpuclk);
    #1;
    check("ares pre vld", 64'(res_vld), 64'd1);
    check("ares pre data", res_data, 64'd2);
    #2 cpurst_b = 1'b0;
    #1;
    check("ares vld", 64'(res_vld), 64'd0);
    check("ares data", res_data, 64'd0);
    check("ares tag", 64'(res_tag), 64'd0);
    check("ares id", 64'(res_id), 64'd0);
    check("ares ff", 64'(res_fflags), 64'd0);
    check("ares rdy", 64'(req_rdy), 64'd1);
    @(negedge cpuclk);
    cpurst_b = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
